// File: rtl/perf_event_arbiter.sv
// Round-robin arbiter that merges per-source performance events into one logging channel.
// Optional per-source drop counters are built when PERF_ARB_DROP_COUNT_EN is defined.
module perf_event_arbiter #(
  parameter int NUM_SRC = 4,
  parameter int DEPTH   = 2,
  parameter int TAG_W   = 32
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [63:0]                  globalCycle,
  input  logic [NUM_SRC-1:0]           src_valid,
  input  logic [NUM_SRC-1:0]           src_rd,
  input  logic [NUM_SRC-1:0]           src_wr,
  input  logic [NUM_SRC*TAG_W-1:0]     src_tag,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(NUM_SRC)-1:0]   out_src,
  output logic                         out_rd,
  output logic                         out_wr,
  output logic [TAG_W-1:0]             out_tag,
  output logic [63:0]                  out_cycle,
  output logic [31:0]                  out_seq
`ifdef PERF_ARB_DROP_COUNT_EN
  ,
  output logic [NUM_SRC*16-1:0]        drop_count
`endif
);

  localparam int SRC_W = $clog2(NUM_SRC);
  localparam int AW    = $clog2(DEPTH);
  localparam int EW    = 2 + TAG_W + 64;

  logic [EW-1:0]    mem    [NUM_SRC][DEPTH];
  logic [AW-1:0]    wr_ptr [NUM_SRC];
  logic [AW-1:0]    rd_ptr [NUM_SRC];
  logic [AW:0]      count  [NUM_SRC];
  logic [SRC_W-1:0] rr;
  logic [31:0]      seq;

  logic               load_en;
  logic               grant_any;
  logic [SRC_W-1:0]   grant_idx;
  logic [SRC_W-1:0]   sel;
  logic [NUM_SRC-1:0] pop;
  logic [NUM_SRC-1:0] accept;
  logic [EW-1:0]      head;
  int                 idx;

  // Scan from the highest offset down so the source closest to rr wins.
  always_comb begin
    load_en   = !out_valid || out_ready;
    grant_any = 1'b0;
    grant_idx = '0;
    idx       = 0;
    sel       = '0;
    for (int k = NUM_SRC - 1; k >= 0; k--) begin
      idx = (int'(rr) + k) % NUM_SRC;
      sel = SRC_W'(idx);
      if (count[sel] != '0) begin
        grant_any = 1'b1;
        grant_idx = sel;
      end
    end
    head = mem[grant_idx][rd_ptr[grant_idx]];
    pop    = '0;
    accept = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      pop[i]    = load_en && grant_any && (grant_idx == SRC_W'(i));
      accept[i] = src_valid[i] && ((count[i] != (AW+1)'(DEPTH)) || pop[i]);
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (accept[i] && !reset)
        mem[i][wr_ptr[i]] <= {src_rd[i], src_wr[i], src_tag[i*TAG_W +: TAG_W], globalCycle};
    end
  end

`ifdef PERF_ARB_DROP_COUNT_EN
  logic [15:0] drop_cnt [NUM_SRC];

  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_SRC; i++) begin
      if (reset)
        drop_cnt[i] <= '0;
      else if (src_valid[i] && !accept[i] && (drop_cnt[i] != 16'hFFFF))
        drop_cnt[i] <= drop_cnt[i] + 16'd1;
    end
  end

  always_comb begin
    drop_count = '0;
    for (int i = 0; i < NUM_SRC; i++)
      drop_count[i*16 +: 16] = drop_cnt[i];
  end
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_src   <= '0;
      out_rd    <= 1'b0;
      out_wr    <= 1'b0;
      out_tag   <= '0;
      out_cycle <= '0;
      out_seq   <= '0;
      seq       <= '0;
      rr        <= '0;
      for (int i = 0; i < NUM_SRC; i++) begin
        wr_ptr[i] <= '0;
        rd_ptr[i] <= '0;
        count[i]  <= '0;
      end
    end else begin
      if (load_en) begin
        out_valid <= grant_any;
        if (grant_any) begin
          {out_rd, out_wr, out_tag, out_cycle} <= head;
          out_src <= grant_idx;
          out_seq <= seq;
          seq     <= seq + 32'd1;
          rr      <= (grant_idx == SRC_W'(NUM_SRC - 1)) ? '0 : grant_idx + 1'b1;
        end
      end
      // Pointers wrap naturally because DEPTH is a power of two.
      for (int i = 0; i < NUM_SRC; i++) begin
        if (accept[i])
          wr_ptr[i] <= wr_ptr[i] + 1'b1;
        if (pop[i])
          rd_ptr[i] <= rd_ptr[i] + 1'b1;
        count[i] <= count[i] + {{AW{1'b0}}, accept[i]} - {{AW{1'b0}}, pop[i]};
      end
    end
  end

endmodule

// File: tb/tb_perf_event_arbiter.sv
// Bench for perf_event_arbiter: constant-vector table, directed corner sequences,
// and randomized traffic against a queue-based reference model.
module tb_perf_event_arbiter;
  localparam int NS    = 4;
  localparam int DEPTH = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [63:0]  globalCycle;
  logic [3:0]   src_valid, src_rd, src_wr;
  logic [127:0] src_tag;
  logic         out_valid, out_ready, out_rd, out_wr;
  logic [1:0]   out_src;
  logic [31:0]  out_tag, out_seq;
  logic [63:0]  out_cycle;
`ifdef PERF_ARB_DROP_COUNT_EN
  logic [63:0]  drop_count;
`endif

  always #5 clk = ~clk;

  perf_event_arbiter #(.NUM_SRC(NS), .DEPTH(DEPTH), .TAG_W(32)) dut (
    .clk(clk), .reset(reset), .globalCycle(globalCycle),
    .src_valid(src_valid), .src_rd(src_rd), .src_wr(src_wr), .src_tag(src_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_src(out_src),
    .out_rd(out_rd), .out_wr(out_wr), .out_tag(out_tag),
    .out_cycle(out_cycle), .out_seq(out_seq)
`ifdef PERF_ARB_DROP_COUNT_EN
    , .drop_count(drop_count)
`endif
  );

  int vectors = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference model: one queue per source plus a single held output record.
  typedef struct packed {
    logic        rd;
    logic        wr;
    logic [31:0] tag;
    logic [63:0] cyc;
  } ev_t;

  ev_t         q [NS][$];
  logic        m_ov;
  int          m_src;
  ev_t         m_rec;
  logic [31:0] m_seq_out, m_seq;
  int          m_rr;
  int          m_drop [NS];

  task automatic model_edge();
    int  g;
    ev_t e;
    if (reset) begin
      for (int i = 0; i < NS; i++) begin
        q[i].delete();
        m_drop[i] = 0;
      end
      m_ov = 0; m_src = 0; m_rec = '0; m_seq_out = 0; m_seq = 0; m_rr = 0;
    end else begin
      if (!m_ov || out_ready) begin
        g = -1;
        for (int k = 0; k < NS; k++) begin
          int n = (m_rr + k) % NS;
          if (g < 0 && q[n].size() > 0) g = n;
        end
        if (g >= 0) begin
          m_rec     = q[g].pop_front();
          m_ov      = 1;
          m_src     = g;
          m_seq_out = m_seq;
          m_seq     = m_seq + 32'd1;
          m_rr      = (g + 1) % NS;
        end else begin
          m_ov = 0;
        end
      end
      for (int i = 0; i < NS; i++) begin
        if (src_valid[i]) begin
          if (q[i].size() < DEPTH) begin
            e.rd = src_rd[i]; e.wr = src_wr[i];
            e.tag = src_tag[i*32 +: 32]; e.cyc = globalCycle;
            q[i].push_back(e);
          end else if (m_drop[i] < 16'hFFFF) begin
            m_drop[i]++;
          end
        end
      end
    end
  endtask

  task automatic compare_model();
    check("out_valid", out_valid, m_ov);
    if (m_ov) begin
      check("out_src", out_src, m_src);
      check("out_rd", out_rd, m_rec.rd);
      check("out_wr", out_wr, m_rec.wr);
      check("out_tag", out_tag, m_rec.tag);
      check("out_cycle", out_cycle, m_rec.cyc);
      check("out_seq", out_seq, m_seq_out);
    end
`ifdef PERF_ARB_DROP_COUNT_EN
    for (int i = 0; i < NS; i++)
      check($sformatf("drop_count[%0d]", i), drop_count[i*16 +: 16], m_drop[i]);
`endif
  endtask

  task automatic step(input logic rst, input logic [3:0] v, input logic [3:0] rd,
                      input logic [3:0] wr, input logic [127:0] tag, input logic rdy,
                      input logic [63:0] gcv);
    reset = rst; src_valid = v; src_rd = rd; src_wr = wr; src_tag = tag;
    out_ready = rdy; globalCycle = gcv;
    @(posedge clk);
    model_edge();
    #1;
    compare_model();
  endtask

  typedef struct {
    logic         rst;
    logic [3:0]   v, rd, wr;
    logic [127:0] tag;
    logic         rdy;
    logic [63:0]  gc;
    logic         e_ov;
    logic [1:0]   e_src;
    logic         e_rd, e_wr;
    logic [31:0]  e_tag;
    logic [63:0]  e_cyc;
    logic [31:0]  e_seq;
  } vec_t;

  function automatic vec_t mk(logic rst, logic [3:0] v, logic [3:0] rd, logic [3:0] wr,
                              logic [127:0] tag, logic [63:0] gc, logic ov, logic [1:0] s,
                              logic erd, logic ewr, logic [31:0] etag, logic [63:0] ecyc,
                              logic [31:0] eseq);
    vec_t r;
    r.rst = rst; r.v = v; r.rd = rd; r.wr = wr; r.tag = tag; r.rdy = 1'b1; r.gc = gc;
    r.e_ov = ov; r.e_src = s; r.e_rd = erd; r.e_wr = ewr; r.e_tag = etag;
    r.e_cyc = ecyc; r.e_seq = eseq;
    return r;
  endfunction

  vec_t tbl [12];
  logic [63:0] prev_cyc;
  logic [63:0] gcnt;

  initial begin
    reset = 1'b1; src_valid = '0; src_rd = '0; src_wr = '0; src_tag = '0;
    out_ready = 1'b0; globalCycle = '0; gcnt = 64'd5000;

    step(1, 0, 0, 0, '0, 0, 0);
    step(1, 0, 0, 0, '0, 0, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_src", out_src, 0);
    check("rst_out_tag", out_tag, 0);
    check("rst_out_cycle", out_cycle, 0);
    check("rst_out_seq", out_seq, 0);

    // Single event on source 2, then the fairness pattern after a reset.
    tbl[0]  = mk(0, 4'b0100, 4'b0100, 4'b0000, {32'h0, 32'h55, 32'h0, 32'h0}, 100, 0, 0, 0, 0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, '0, 101, 1, 2, 1, 0, 32'h55, 100, 0);
    tbl[2]  = mk(0, 0, 0, 0, '0, 102, 0, 0, 0, 0, 0, 0, 0);
    tbl[3]  = mk(1, 0, 0, 0, '0, 103, 0, 0, 0, 0, 0, 0, 0);
    tbl[4]  = mk(0, 4'b1111, 4'b0101, 4'b0011, {32'hA3, 32'hA2, 32'hA1, 32'hA0}, 200, 0, 0, 0, 0, 0, 0, 0);
    tbl[5]  = mk(0, 0, 0, 0, '0, 201, 1, 0, 1, 1, 32'hA0, 200, 0);
    tbl[6]  = mk(0, 0, 0, 0, '0, 202, 1, 1, 0, 1, 32'hA1, 200, 1);
    tbl[7]  = mk(0, 0, 0, 0, '0, 203, 1, 2, 1, 0, 32'hA2, 200, 2);
    tbl[8]  = mk(0, 4'b1001, 4'b1001, 4'b1000, {32'hB3, 32'h0, 32'h0, 32'hB0}, 300, 1, 3, 0, 0, 32'hA3, 200, 3);
    tbl[9]  = mk(0, 0, 0, 0, '0, 301, 1, 0, 1, 0, 32'hB0, 300, 4);
    tbl[10] = mk(0, 0, 0, 0, '0, 302, 1, 3, 1, 1, 32'hB3, 300, 5);
    tbl[11] = mk(0, 0, 0, 0, '0, 303, 0, 0, 0, 0, 0, 0, 0);

    for (int n = 0; n < 12; n++) begin
      step(tbl[n].rst, tbl[n].v, tbl[n].rd, tbl[n].wr, tbl[n].tag, tbl[n].rdy, tbl[n].gc);
      check($sformatf("tbl%0d_valid", n), out_valid, tbl[n].e_ov);
      if (tbl[n].e_ov) begin
        check($sformatf("tbl%0d_src", n), out_src, tbl[n].e_src);
        check($sformatf("tbl%0d_rd", n), out_rd, tbl[n].e_rd);
        check($sformatf("tbl%0d_wr", n), out_wr, tbl[n].e_wr);
        check($sformatf("tbl%0d_tag", n), out_tag, tbl[n].e_tag);
        check($sformatf("tbl%0d_cycle", n), out_cycle, tbl[n].e_cyc);
        check($sformatf("tbl%0d_seq", n), out_seq, tbl[n].e_seq);
      end
    end

    // Back-pressure: source 1 fires five times with the sink stalled.
    step(1, 0, 0, 0, '0, 0, 0);
    for (int k = 0; k < 5; k++)
      step(0, 4'b0010, 4'b0010, 0, {64'h0, 32'h10 + k, 32'h0}, 0, 1000 + k);
    check("bp_held_valid", out_valid, 1);
    check("bp_held_tag", out_tag, 32'h10);
`ifdef PERF_ARB_DROP_COUNT_EN
    check("bp_drop_count1", drop_count[31:16], 2);
`endif
    prev_cyc = out_cycle;
    for (int k = 1; k < 3; k++) begin
      step(0, 0, 0, 0, '0, 1, 1010 + k);
      check("bp_release_tag", out_tag, 32'h10 + k);
      check("bp_cycle_increasing", out_cycle > prev_cyc, 1);
      prev_cyc = out_cycle;
    end
    step(0, 0, 0, 0, '0, 1, 1013);
    check("bp_drained", out_valid, 0);

    // Full FIFO with a same-edge pop must accept every event.
    step(1, 0, 0, 0, '0, 0, 0);
    for (int k = 0; k < 3; k++)
      step(0, 4'b0001, 0, 0, {96'h0, 32'h20 + k}, 0, 2000 + k);
    for (int k = 0; k < 8; k++) begin
      step(0, 4'b0001, 0, 0, {96'h0, 32'h23 + k}, 1, 2003 + k);
      check("full_pop_valid", out_valid, 1);
      check("full_pop_tag", out_tag, 32'h21 + k);
      check("full_pop_seq", out_seq, 1 + k);
    end
`ifdef PERF_ARB_DROP_COUNT_EN
    check("full_pop_no_drop", drop_count[15:0], 0);
`endif
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, '0, 1, 2020 + k);

    // Reset while records are held and buffered.
    step(0, 4'b0111, 0, 0, {32'h0, 32'h32, 32'h31, 32'h30}, 0, 3000);
    step(0, 4'b0010, 0, 0, {64'h0, 32'h33, 32'h0}, 0, 3001);
    step(0, 4'b0010, 0, 0, {64'h0, 32'h34, 32'h0}, 0, 3002);
    step(1, 0, 0, 0, '0, 1, 3003);
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_rr", dut.rr, 0);
`ifdef PERF_ARB_DROP_COUNT_EN
    check("mid_rst_drop", drop_count, 0);
`endif
    step(0, 4'b1000, 0, 4'b1000, {32'h40, 96'h0}, 1, 3004);
    step(0, 0, 0, 0, '0, 1, 3005);
    check("post_rst_valid", out_valid, 1);
    check("post_rst_src", out_src, 3);
    check("post_rst_seq", out_seq, 0);
    step(0, 0, 0, 0, '0, 1, 3006);

    // Sequence wrap through a deposited counter value.
    dut.seq = 32'hFFFF_FFFF;
    m_seq   = 32'hFFFF_FFFF;
    step(0, 4'b0110, 0, 0, {32'h0, 32'h52, 32'h51, 32'h0}, 1, 4000);
    step(0, 0, 0, 0, '0, 1, 4001);
    check("wrap_seq_max", out_seq, 32'hFFFF_FFFF);
    step(0, 0, 0, 0, '0, 1, 4002);
    check("wrap_seq_zero", out_seq, 0);
    step(0, 0, 0, 0, '0, 1, 4003);

    // Randomized traffic checked against the model on every cycle.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(199) == 0), 4'($urandom_range(15) & $urandom_range(15)),
           4'($urandom()), 4'($urandom()),
           {$urandom(), $urandom(), $urandom(), $urandom()},
           ($urandom_range(9) < 7), gcnt);
      gcnt = gcnt + 64'd1 + 64'($urandom_range(2));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
